// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        COUNT = 3'd2,
        WHI   = 3'd3,
        WLO   = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_e;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int unsigned CSUM_W            = 8;
    // Remaining-word counter must hold 256.
    localparam int unsigned CNT_W             = 9;

    // True in the states that consume bytes from the receive FIFO.
    function automatic logic is_rx_state(input state_e s);
        return (s == SYNC) || (s == COUNT) || (s == WHI) || (s == WLO) || (s == CSUM);
    endfunction

endpackage

// File: rtl/uart_byte_reader.sv
// Pops one byte at a time from the UART receive FIFO, never on back-to-back cycles.
module uart_byte_reader (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rx_en,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic       rd_q, rd_d;
    logic       vld_q, vld_d;
    logic [7:0] byte_q, byte_d;

    // Issue a pop only when the previous pop has had a cycle to settle; start takes priority.
    always_comb begin
        rd_d   = 1'b0;
        vld_d  = 1'b0;
        byte_d = byte_q;
        if (rx_en && !rx_empty && !rd_q && !start) begin
            rd_d   = 1'b1;
            vld_d  = 1'b1;
            byte_d = r_data;
        end
    end

    // Pop strobe and captured byte registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q   <= 1'b0;
            vld_q  <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            rd_q   <= rd_d;
            vld_q  <= vld_d;
            byte_q <= byte_d;
        end
    end

    assign rd_uart    = rd_q;
    assign byte_valid = vld_q;
    assign byte_data  = byte_q;

endmodule

// File: rtl/uart_instr_loader.sv
// Loads a framed, checksummed instruction image from the UART into instruction memory.
module uart_instr_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        r_data,
    input  logic              rx_empty,
    output logic              rd_uart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CSUM_W-1:0]   csum_q, csum_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                byte_valid;
    logic [7:0]          byte_data;

    uart_byte_reader u_reader (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rx_en      (is_rx_state(state_q)),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    // Frame parser: next state and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;

        if (start) begin
            state_d   = SYNC;
            addr_d    = '0;
            csum_d    = '0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            cpu_rst_d = 1'b0;
        end else begin
            // Advance the address after a write only if more words follow, so it never wraps.
            if (we_q && (state_q == WHI)) begin
                addr_d = addr_q + ADDR_W'(1);
            end
            if (byte_valid) begin
                unique case (state_q)
                    SYNC: begin
                        if (byte_data == SYNC_BYTE) state_d = COUNT;
                    end
                    COUNT: begin
                        cnt_d   = (byte_data == 8'h00) ? CNT_W'(256) : CNT_W'(byte_data);
                        state_d = WHI;
                    end
                    WHI: begin
                        hi_d    = byte_data;
                        csum_d  = csum_q + byte_data;
                        state_d = WLO;
                    end
                    WLO: begin
                        wdata_d = {hi_q, byte_data};
                        we_d    = 1'b1;
                        csum_d  = csum_q + byte_data;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = CSUM;
                        end else begin
                            cnt_d   = cnt_q - CNT_W'(1);
                            state_d = WHI;
                        end
                    end
                    CSUM: begin
                        if (byte_data == csum_q) begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            cpu_rst_d = 1'b1;
                        end else begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        busy_d = is_rx_state(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            csum_q    <= '0;
            hi_q      <= 8'h00;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            we_q      <= 1'b0;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            hi_q      <= hi_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_reset_n = cpu_rst_q;
    assign busy        = busy_q;
    assign load_done   = done_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader with a queue-based receive FIFO model.
`timescale 1ns/1ps
module tb_uart_instr_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  r_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rd_uart;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset_n;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int tests = 0;
    int fails = 0;
    int pops = 0;
    int b2b = 0;
    logic prev_rd = 1'b0;

    logic [7:0]  fifo[$];
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    uart_instr_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .r_data      (r_data),
        .rx_empty    (rx_empty),
        .rd_uart     (rd_uart),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    // FIFO model: apply pops and refresh head/empty mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rd_uart) begin
            pops++;
            if (prev_rd) b2b++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        prev_rd = rd_uart;
        rx_empty = (fifo.size() == 0);
        r_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    // Write monitor.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        wr_addr.delete();
        wr_data.delete();
        pops = 0;
        b2b = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_writes(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (wr_addr.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n >= budget), 32'd0);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_rd_uart", rd_uart, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_reset_n", cpu_reset_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Two-word frame, checksum 12+34+AB+CD = 1BE -> BE
        pulse_start();
        #1;
        chk("t1_busy_after_start", busy, 1);
        chk("t1_cpu_held", cpu_reset_n, 0);
        push(8'hA5); push(8'h02); push(8'h12); push(8'h34);
        push(8'hAB); push(8'hCD); push(8'hBE);
        wait_idle("t1", 200);
        chk("t1_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            chk("t1_addr0", wr_addr[0], 8'h00);
            chk("t1_data0", wr_data[0], 16'h1234);
            chk("t1_addr1", wr_addr[1], 8'h01);
            chk("t1_data1", wr_data[1], 16'hABCD);
        end
        chk("t1_done", load_done, 1);
        chk("t1_cpu_run", cpu_reset_n, 1);
        chk("t1_err", load_err, 0);
        chk("t1_pops", pops, 7);

        // Same frame with a wrong checksum 8E
        pulse_start();
        #1;
        chk("t1b_done_cleared", load_done, 0);
        push(8'hA5); push(8'h02); push(8'h12); push(8'h34);
        push(8'hAB); push(8'hCD); push(8'h8E);
        wait_idle("t1b", 200);
        chk("t1b_err", load_err, 1);
        chk("t1b_done", load_done, 0);
        chk("t1b_cpu_held", cpu_reset_n, 0);

        // One-word frame with bad checksum; FIFO holds all 5 bytes
        pulse_start();
        push(8'hA5); push(8'h01); push(8'h00); push(8'h01); push(8'h05);
        wait_idle("t2", 200);
        chk("t2_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() >= 1) begin
            chk("t2_addr0", wr_addr[0], 8'h00);
            chk("t2_data0", wr_data[0], 16'h0001);
        end
        chk("t2_err", load_err, 1);
        chk("t2_cpu_held", cpu_reset_n, 0);
        chk("t2_done", load_done, 0);
        chk("t2_pops", pops, 5);
        chk("t2_no_b2b", b2b, 0);

        // Noise before sync is discarded; BE+EF = 1AD -> AD
        pulse_start();
        #1;
        chk("t3_err_cleared", load_err, 0);
        push(8'h3C); push(8'hFF); push(8'hA5); push(8'h01);
        push(8'hBE); push(8'hEF); push(8'hAD);
        wait_idle("t3", 200);
        chk("t3_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() >= 1) begin
            chk("t3_addr0", wr_addr[0], 8'h00);
            chk("t3_data0", wr_data[0], 16'hBEEF);
        end
        chk("t3_done", load_done, 1);
        chk("t3_pops", pops, 7);
        chk("t3_no_b2b", b2b, 0);

        // Asynchronous reset mid-frame, then a clean reload
        pulse_start();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22);
        push(8'h33); push(8'h44); push(8'h55); push(8'h66); push(8'h00);
        wait_writes("t4_first", 1, 200);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_addr", imem_addr, 0);
        chk("t4_rst_wdata", imem_wdata, 0);
        chk("t4_rst_we", imem_we, 0);
        chk("t4_rst_rd", rd_uart, 0);
        chk("t4_rst_cpu", cpu_reset_n, 0);
        chk("t4_rst_done", load_done, 0);
        chk("t4_rst_err", load_err, 0);
        fifo.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        pulse_start();
        push(8'hA5); push(8'h01); push(8'hCA); push(8'hFE); push(8'hC8);
        wait_idle("t4", 200);
        chk("t4_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() >= 1) begin
            chk("t4_addr0", wr_addr[0], 8'h00);
            chk("t4_data0", wr_data[0], 16'hCAFE);
        end
        chk("t4_done", load_done, 1);

        // Count 00 -> 256 words {i, ~i}; each word sums to FF, total 256*FF mod 256 = 00
        pulse_start();
        push(8'hA5); push(8'h00);
        for (int i = 0; i < 256; i++) begin
            push(8'(i));
            push(~8'(i));
        end
        push(8'h00);
        wait_idle("t5", 5000);
        chk("t5_nwrites", wr_addr.size(), 256);
        if (wr_addr.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                chk($sformatf("t5_addr%0d", i), wr_addr[i], 32'(i));
                chk($sformatf("t5_data%0d", i), wr_data[i], {16'h0, 8'(i), ~8'(i)});
            end
        end
        chk("t5_last_addr", imem_addr, 8'hFF);
        chk("t5_done", load_done, 1);
        chk("t5_err", load_err, 0);
        chk("t5_no_b2b", b2b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
